game_state_ctrl: RTL

//  Master game-flow FSM. Produces the 2-bit screen state consumed by the display layer mux
//  (START / GAME / GAMEOVER). Also turns the raw player button into registered single-cycle

---
 rtl/game_pkg.sv | 24 ++
 rtl/btn_sync_edge.sv | 23 ++
 rtl/game_state_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game-flow types: screen encoding used by the display mux and game logic,
// plus the saturating 2-digit BCD increment used for the score.
package game_pkg;

    typedef enum logic [1:0] {
        ST_START    = 2'b00,
        ST_GAME     = 2'b01,
        ST_GAMEOVER = 2'b10
    } state_t;

    localparam logic [7:0] BCD_MAX = 8'h99;

    // Saturates at 99; the low digit wraps 9 -> 0 with a carry into the high digit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value);
        if (value >= BCD_MAX) begin
            return BCD_MAX;
        end
        if (value[3:0] >= 4'd9) begin
            return {value[7:4] + 4'd1, 4'd0};
        end
        return {value[7:4], value[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for the raw button followed by a rising-edge detector,
// so a held button yields exactly one single-cycle press.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_async,
    output logic press
);

    // Stage 0 and 1 form the synchroniser; stage 2 is the previous synchronised value.
    logic [2:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 3'b000;
        end else begin
            sync_reg <= {sync_reg[1:0], btn_async};
        end
    end

    assign press = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/game_state_ctrl.sv
// Master game-flow controller: owns all screen transitions, turns button presses into
// flap pulses, keeps BCD score/best and holds GAMEOVER for a number of frames.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int HOLD_FRAMES = 120,
    parameter int HOLD_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       frame_tick,
    input  logic       collision,
    input  logic       pipe_passed,
    output logic [1:0] state,
    output logic       game_rst,
    output logic       flap,
    output logic [7:0] score,
    output logic [7:0] best
);

    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

    logic              press;
    logic [1:0]        state_reg, state_next;
    logic              game_rst_reg, game_rst_next;
    logic              flap_reg, flap_next;
    logic [7:0]        score_reg, score_next;
    logic [7:0]        best_reg, best_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;

    btn_sync_edge u_btn_sync_edge (
        .clk       (clk),
        .rst       (rst),
        .btn_async (btn),
        .press     (press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_START;
            game_rst_reg <= 1'b0;
            flap_reg     <= 1'b0;
            score_reg    <= 8'h00;
            best_reg     <= 8'h00;
            hold_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            game_rst_reg <= game_rst_next;
            flap_reg     <= flap_next;
            score_reg    <= score_next;
            best_reg     <= best_next;
            hold_reg     <= hold_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        game_rst_next = 1'b0;
        flap_next     = 1'b0;
        score_next    = score_reg;
        best_next     = best_reg;
        hold_next     = hold_reg;
        case (state_reg)
            ST_START: begin
                // The starting press only launches the run; it never doubles as a flap.
                if (press) begin
                    state_next    = ST_GAME;
                    game_rst_next = 1'b1;
                    score_next    = 8'h00;
                end
            end
            ST_GAME: begin
                if (collision) begin
                    state_next = ST_GAMEOVER;
                    hold_next  = HOLD_INIT;
                    if (score_reg > best_reg) begin
                        best_next = score_reg;
                    end
                end else begin
                    if (pipe_passed) begin
                        score_next = bcd_inc(score_reg);
                    end
                    flap_next = press;
                end
            end
            ST_GAMEOVER: begin
                // A press in the same cycle the hold expires is still swallowed.
                if (hold_reg != '0) begin
                    if (frame_tick) begin
                        hold_next = hold_reg - 1'b1;
                    end
                end else if (press) begin
                    state_next = ST_START;
                end
            end
            default: begin
                state_next = ST_START;
            end
        endcase
    end

    assign state    = state_reg;
    assign game_rst = game_rst_reg;
    assign flap     = flap_reg;
    assign score    = score_reg;
    assign best     = best_reg;

endmodule
